// File: rtl/tri_wave_monitor.sv
// Protocol checker and period meter for the 8-bit up/down triangle counter output.
// Optional build macro TRI_MON_ERR_CNT_EN adds a saturating violation counter (err_cnt).
//
// state    | meaning
// S_INIT   | unlocked, resyncing on the next legal step
// S_RISE   | counting up toward TOP
// S_TOP    | one-cycle hold at TOP seen
// S_FALL   | counting down toward 0
// S_BOTTOM | one-cycle hold at 0 seen
module tri_wave_monitor #(
  parameter int DATA_W = 8,
  parameter int TOP    = 32,
  parameter int PER_W  = 16
) (
  input  logic              clock,
  input  logic              areset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_clr,
  output logic              locked,
  output logic              peak_evt,
  output logic              valley_evt,
  output logic [PER_W-1:0]  period_out,
  output logic              period_valid,
  output logic              err,
  output logic              err_sticky
`ifdef TRI_MON_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic [2:0] {S_INIT, S_RISE, S_TOP, S_FALL, S_BOTTOM} state_t;

  localparam logic [DATA_W:0] TOP_X = (DATA_W+1)'(TOP);
  localparam logic [DATA_W:0] ONE_X = {{DATA_W{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  prev_q;
  logic               prev_valid_q;
  logic [PER_W-1:0]   period_cnt_q;
  logic               valley_seen_q;
  logic               locked_q, peak_q, valley_q, err_q, sticky_q, pvalid_q;
  logic [PER_W-1:0]   period_q;
  logic               peak_d, valley_d, err_d, locked_d;
  logic [PER_W-1:0]   period_inc;

  logic [DATA_W:0] data_x, prev_x;
  logic            in_range, step_up, step_down, step_hold, prev_top, prev_zero;

  // Widened by one bit so prev+1 at the top of the range cannot wrap onto 0.
  assign data_x    = {1'b0, data_in};
  assign prev_x    = {1'b0, prev_q};
  assign in_range  = (data_x <= TOP_X);
  assign prev_top  = (prev_x == TOP_X);
  assign prev_zero = (prev_q == '0);
  assign step_up   = in_range && (data_x == prev_x + ONE_X);
  assign step_down = in_range && !prev_zero && (data_x == prev_x - ONE_X);
  assign step_hold = in_range && (data_in == prev_q);

  assign period_inc = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + PER_W'(1);

  always_comb begin
    state_d  = state_q;
    peak_d   = 1'b0;
    valley_d = 1'b0;
    err_d    = 1'b0;
    if (prev_valid_q) begin
      case (state_q)
        S_INIT: begin
          if (step_up)                      state_d = S_RISE;
          else if (step_down)               state_d = S_FALL;
          else if (step_hold && prev_top)   state_d = S_TOP;
          else if (step_hold && prev_zero)  state_d = S_BOTTOM;
        end
        S_RISE: begin
          if (step_up)                      state_d = S_RISE;
          else if (step_hold && prev_top)   state_d = S_TOP;
          else                              err_d   = 1'b1;
        end
        S_TOP: begin
          if (step_down) begin
            state_d = S_FALL;
            peak_d  = 1'b1;
          end else                          err_d   = 1'b1;
        end
        S_FALL: begin
          if (step_down)                    state_d = S_FALL;
          else if (step_hold && prev_zero)  state_d = S_BOTTOM;
          else                              err_d   = 1'b1;
        end
        S_BOTTOM: begin
          if (step_up) begin
            state_d  = S_RISE;
            valley_d = 1'b1;
          end else                          err_d   = 1'b1;
        end
        default:                            state_d = S_INIT;
      endcase
    end
    if (err_d) state_d = S_INIT;
    locked_d = (state_d != S_INIT);
  end

  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      state_q       <= S_INIT;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      period_cnt_q  <= '0;
      valley_seen_q <= 1'b0;
      locked_q      <= 1'b0;
      peak_q        <= 1'b0;
      valley_q      <= 1'b0;
      err_q         <= 1'b0;
      sticky_q      <= 1'b0;
      pvalid_q      <= 1'b0;
      period_q      <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= data_in;
      prev_valid_q <= 1'b1;
      locked_q     <= locked_d;
      peak_q       <= peak_d;
      valley_q     <= valley_d;
      err_q        <= err_d;
      if (valley_d) begin
        period_cnt_q  <= '0;
        valley_seen_q <= 1'b1;
        if (valley_seen_q) begin
          period_q <= period_inc;
          pvalid_q <= 1'b1;
        end
      end else if (state_q != S_INIT) begin
        period_cnt_q <= period_inc;
      end
      if (err_d) begin
        pvalid_q      <= 1'b0;
        valley_seen_q <= 1'b0;
      end
      // A violation in the same cycle as err_clr keeps the flag set.
      if (err_d)        sticky_q <= 1'b1;
      else if (err_clr) sticky_q <= 1'b0;
    end
  end

  assign locked       = locked_q;
  assign peak_evt     = peak_q;
  assign valley_evt   = valley_q;
  assign period_out   = period_q;
  assign period_valid = pvalid_q;
  assign err          = err_q;
  assign err_sticky   = sticky_q;

`ifdef TRI_MON_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      err_cnt_q <= 8'd0;
    end else if (err_clr) begin
      err_cnt_q <= err_d ? 8'd1 : 8'd0;
    end else if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tri_wave_monitor.sv
// Scoreboard bench for tri_wave_monitor: a profile-rule model queues expected outputs per sample,
// a monitor pops and compares one entry after every clock edge.
module tb_tri_wave_monitor;

  localparam int TOPV = 32;

  logic        clock;
  logic        areset;
  logic [7:0]  data_in;
  logic        err_clr;
  logic        locked, peak_evt, valley_evt, period_valid, err, err_sticky;
  logic [15:0] period_out;
`ifdef TRI_MON_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  tri_wave_monitor #(.DATA_W(8), .TOP(TOPV), .PER_W(16)) dut (
    .clock        (clock),
    .areset       (areset),
    .data_in      (data_in),
    .err_clr      (err_clr),
    .locked       (locked),
    .peak_evt     (peak_evt),
    .valley_evt   (valley_evt),
    .period_out   (period_out),
    .period_valid (period_valid),
    .err          (err),
    .err_sticky   (err_sticky)
`ifdef TRI_MON_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int locked;
    int peak;
    int valley;
    int period;
    int pvalid;
    int err;
    int sticky;
    int cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: profile phase name, sample index, index of the last valley.
  localparam int P_INIT = 0, P_UP = 1, P_PEAK = 2, P_DOWN = 3, P_FLOOR = 4;
  int m_phase, m_prev, m_have_prev, m_idx, m_last_valley;
  int m_period, m_pvalid, m_sticky, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_INIT; m_prev = 0; m_have_prev = 0; m_idx = 0; m_last_valley = -1;
    m_period = 0; m_pvalid = 0; m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_step(input int d, input int clr);
    exp_t e;
    bit up, dn, hd, bad;
    int pk, vl;
    pk = 0; vl = 0; bad = 0;
    up = m_have_prev != 0 && d <= TOPV && d == m_prev + 1;
    dn = m_have_prev != 0 && d <= TOPV && m_prev > 0 && d == m_prev - 1;
    hd = m_have_prev != 0 && d <= TOPV && d == m_prev;
    if (m_have_prev != 0) begin
      case (m_phase)
        P_INIT: begin
          if (up) m_phase = P_UP;
          else if (dn) m_phase = P_DOWN;
          else if (hd && d == TOPV) m_phase = P_PEAK;
          else if (hd && d == 0) m_phase = P_FLOOR;
        end
        P_UP:    if (up) m_phase = P_UP; else if (hd && d == TOPV) m_phase = P_PEAK; else bad = 1;
        P_PEAK:  if (dn) begin m_phase = P_DOWN; pk = 1; end else bad = 1;
        P_DOWN:  if (dn) m_phase = P_DOWN; else if (hd && d == 0) m_phase = P_FLOOR; else bad = 1;
        default: if (up) begin m_phase = P_UP; vl = 1; end else bad = 1;
      endcase
    end
    if (bad) begin
      m_phase = P_INIT;
      m_pvalid = 0;
      m_last_valley = -1;
    end
    if (vl) begin
      if (m_last_valley >= 0) begin
        m_period = m_idx - m_last_valley;
        m_pvalid = 1;
      end
      m_last_valley = m_idx;
    end
    if (bad) m_sticky = 1; else if (clr != 0) m_sticky = 0;
    if (clr != 0) m_cnt = bad ? 1 : 0;
    else if (bad && m_cnt < 255) m_cnt++;
    m_prev = d; m_have_prev = 1; m_idx++;
    e.locked = (m_phase != P_INIT); e.peak = pk; e.valley = vl;
    e.period = m_period; e.pvalid = m_pvalid; e.err = bad ? 1 : 0;
    e.sticky = m_sticky; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic drive(input int d, input int clr);
    @(negedge clock);
    areset  = 1'b1;
    data_in = 8'(d);
    err_clr = (clr != 0);
    model_step(d, clr);
  endtask

  function automatic int tri_val(input int k);
    int p;
    p = k % 66;
    if (p <= 32) return p;
    if (p == 33) return 32;
    return 65 - p;
  endfunction

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic run_tri(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      drive(tri_val(k), 0);
      if (k == 67) begin
        settle();
        chk("first_valley_evt", valley_evt, 1);
        chk("first_valley_no_period", period_valid, 0);
      end
      if (k == 133) begin
        settle();
        chk("second_valley_period", period_out, 66);
        chk("second_valley_pvalid", period_valid, 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_peak"}, peak_evt, 0);
    chk({tag, "_valley"}, valley_evt, 0);
    chk({tag, "_period"}, period_out, 0);
    chk({tag, "_pvalid"}, period_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_sticky"}, err_sticky, 0);
`ifdef TRI_MON_ERR_CNT_EN
    chk({tag, "_cnt"}, err_cnt, 0);
`endif
  endtask

  // Monitor: one expected entry per captured sample, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked", locked, e.locked);
        chk("peak_evt", peak_evt, e.peak);
        chk("valley_evt", valley_evt, e.valley);
        chk("period_out", period_out, e.period);
        chk("period_valid", period_valid, e.pvalid);
        chk("err", err, e.err);
        chk("err_sticky", err_sticky, e.sticky);
`ifdef TRI_MON_ERR_CNT_EN
        chk("err_cnt", err_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    areset = 1'b0; data_in = 8'd0; err_clr = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");

    run_tri(0, 140);

    // Glitch while rising: 5 where 10 is due, then resume.
    drive(9, 0);
    drive(5, 0);
    for (int x = 10; x <= 32; x++) drive(x, 0);
    drive(33, 0);
    settle();
    chk("over_top_err", err, 1);

    // 33 -> 32 relocks falling, then a double hold at 0.
    for (int x = 32; x >= 0; x--) drive(x, 0);
    drive(0, 0);
    drive(0, 0);
    settle();
    chk("double_zero_err", err, 1);

    for (int x = 1; x <= 32; x++) drive(x, 0);
    drive(32, 0);
    drive(32, 0);
    settle();
    chk("double_top_err", err, 1);

    for (int x = 31; x >= 10; x--) drive(x, 0);
    drive(20, 1);
    settle();
    chk("clr_with_bad_sticky", err_sticky, 1);
    drive(21, 1);
    settle();
    chk("clr_alone_sticky", err_sticky, 0);
    drive(22, 0);

    // Async reset mid-fall.
    run_tri(0, 50);
    @(posedge clock);
    #2;
    areset = 1'b0;
    model_reset();
    q.delete();
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clock);
    run_tri(51, 140);

    // Randomized triangle with glitches and clears.
    for (int k = 141; k < 1700; k++) begin
      v = tri_val(k);
      if ($urandom_range(0, 49) == 0) v = $urandom_range(0, 255);
      drive(v, ($urandom_range(0, 39) == 0) ? 1 : 0);
    end

`ifdef TRI_MON_ERR_CNT_EN
    drive(5, 0);
    for (int i = 0; i < 160; i++) begin
      drive(6, 0);
      drive(20, 0);
      drive(21, 0);
      drive(5, 0);
    end
    settle();
    chk("err_cnt_saturated", err_cnt, 255);
`endif

    @(negedge clock);
    err_clr = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
